// File: rtl/diff_link_pkg.sv
// Shared definitions for the single-wire cursor link (receiver and transmitter).
package diff_link_pkg;

    localparam int unsigned CODE_W = 26;

    localparam int unsigned X_MSB   = 25;
    localparam int unsigned X_LSB   = 16;
    localparam int unsigned Y_MSB   = 15;
    localparam int unsigned Y_LSB   = 7;
    localparam int unsigned COL_MSB = 6;
    localparam int unsigned COL_LSB = 3;
    localparam int unsigned SW_MSB  = 2;
    localparam int unsigned SW_LSB  = 0;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } rx_state_t;

    typedef struct packed {
        logic [X_MSB-X_LSB:0]     x;
        logic [Y_MSB-Y_LSB:0]     y;
        logic [COL_MSB-COL_LSB:0] color;
        logic [SW_MSB-SW_LSB:0]   sw;
    } cursor_pkt_t;

    // Even parity bit for a payload (XOR of all data bits).
    function automatic logic even_parity(input logic [CODE_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/diff_rx_frame_bit_timer.sv
// Bit-sampling timer: first tick at the start-bit decision point, then every BIT_PERIOD.
// With DIFF_RX_MAJORITY_EN the tick moves one cycle past mid-bit so a 3-sample vote can be taken.
module diff_rx_frame_bit_timer #(
    parameter int unsigned BIT_PERIOD = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic sample_tick
);

    localparam int unsigned CNT_W = $clog2(BIT_PERIOD) + 1;
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(BIT_PERIOD - 1);
    // Loading here makes the counter reach LAST exactly at the start-bit midpoint.
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(BIT_PERIOD - BIT_PERIOD / 2);
`ifdef DIFF_RX_MAJORITY_EN
    localparam logic [CNT_W-1:0] TICK_AT  = '0;
`else
    localparam logic [CNT_W-1:0] TICK_AT  = LAST;
`endif

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: load wins, otherwise wrap to zero at the mid-bit point.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (load) begin
            cnt_d = LOAD_VAL;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    // Counter and registered tick (tick is high while cnt_q == TICK_AT).
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            sample_tick <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            sample_tick <= (cnt_d == TICK_AT);
        end
    end

endmodule

// File: rtl/diff_rx_frame.sv
// Receive framer for the cursor link: start, CODE_W data bits MSB-first, even parity, stop.
// Optional DIFF_RX_MAJORITY_EN: each bit is the 2-of-3 vote of samples at mid-1, mid, mid+1.
module diff_rx_frame
    import diff_link_pkg::*;
#(
    parameter int unsigned BIT_PERIOD = 100
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              line_in,
    input  logic              rx_en_in,
    output logic [CODE_W-1:0] code_out,
    output logic [9:0]        x_out,
    output logic [8:0]        y_out,
    output logic [3:0]        color_out,
    output logic [2:0]        sw_out,
    output logic              new_code_out,
    output logic              busy_out,
    output logic              parity_err_out,
    output logic              frame_err_out
);

    localparam int unsigned BIT_CNT_W = $clog2(CODE_W);

    rx_state_t             state_q, state_d;
    logic [CODE_W-1:0]     shreg_q, shreg_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic                  par_bad_q, par_bad_d;
    logic [CODE_W-1:0]     code_q, code_d;
    logic                  new_code_d, perr_d, ferr_d, busy_d;
    logic                  load_c;
    logic                  tick;
    logic                  sample_bit_c;

    diff_rx_frame_bit_timer #(
        .BIT_PERIOD (BIT_PERIOD)
    ) u_bit_timer (
        .clk         (clk_in),
        .rst         (rst_in),
        .load        (load_c),
        .sample_tick (tick)
    );

`ifdef DIFF_RX_MAJORITY_EN
    logic [1:0] hist_q;

    // Line history so the vote sees mid-1 and mid alongside the current mid+1 sample.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= {hist_q[0], line_in};
        end
    end

    assign sample_bit_c = (hist_q[1] & hist_q[0]) | (hist_q[1] & line_in) | (hist_q[0] & line_in);
`else
    assign sample_bit_c = line_in;
`endif

    // Next-state and next-output logic; losing the enable aborts any frame silently.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        par_bad_d  = par_bad_q;
        code_d     = code_q;
        new_code_d = 1'b0;
        perr_d     = 1'b0;
        ferr_d     = 1'b0;
        load_c     = 1'b0;

        if ((state_q != IDLE) && !rx_en_in) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!line_in && rx_en_in) begin
                        load_c  = 1'b1;
                        state_d = START;
                    end
                end
                START: begin
                    if (tick) begin
                        if (sample_bit_c) begin
                            state_d = IDLE;
                        end else begin
                            bit_cnt_d = '0;
                            state_d   = DATA;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        shreg_d   = {shreg_q[CODE_W-2:0], sample_bit_c};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == BIT_CNT_W'(CODE_W - 1)) begin
                            state_d = PARITY;
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        par_bad_d = even_parity(shreg_q) ^ sample_bit_c;
                        state_d   = STOP;
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (!sample_bit_c) begin
                            ferr_d  = 1'b1;
                            state_d = WAIT_HIGH;
                        end else if (par_bad_q) begin
                            perr_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            code_d     = shreg_q;
                            new_code_d = 1'b1;
                            state_d    = IDLE;
                        end
                    end
                end
                WAIT_HIGH: begin
                    if (line_in) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q        <= IDLE;
            shreg_q        <= '0;
            bit_cnt_q      <= '0;
            par_bad_q      <= 1'b0;
            code_q         <= '0;
            new_code_out   <= 1'b0;
            parity_err_out <= 1'b0;
            frame_err_out  <= 1'b0;
            busy_out       <= 1'b0;
        end else begin
            state_q        <= state_d;
            shreg_q        <= shreg_d;
            bit_cnt_q      <= bit_cnt_d;
            par_bad_q      <= par_bad_d;
            code_q         <= code_d;
            new_code_out   <= new_code_d;
            parity_err_out <= perr_d;
            frame_err_out  <= ferr_d;
            busy_out       <= busy_d;
        end
    end

    assign code_out  = code_q;
    assign x_out     = code_q[X_MSB:X_LSB];
    assign y_out     = code_q[Y_MSB:Y_LSB];
    assign color_out = code_q[COL_MSB:COL_LSB];
    assign sw_out    = code_q[SW_MSB:SW_LSB];

endmodule

// File: tb/tb_diff_rx_frame.sv
// Directed bench for diff_rx_frame at BIT_PERIOD=8; DIFF_RX_MAJORITY_EN adds the glitch-vote scenario.
module tb_diff_rx_frame;

    localparam int unsigned P    = 8;
    localparam int unsigned HALF = P / 2;
`ifdef DIFF_RX_MAJORITY_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif
    // Cycles from the start-bit drive point to the new_code_out pulse.
    localparam int LAT = 1 + 28 * P + HALF + EXTRA;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        line_in;
    logic        rx_en_in;
    logic [25:0] code_out;
    logic [9:0]  x_out;
    logic [8:0]  y_out;
    logic [3:0]  color_out;
    logic [2:0]  sw_out;
    logic        new_code_out;
    logic        busy_out;
    logic        parity_err_out;
    logic        frame_err_out;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int new_cnt = 0;
    int perr_cnt = 0;
    int ferr_cnt = 0;
    int last_new_cyc = 0;
    int start_cyc = 0;

    diff_rx_frame #(
        .BIT_PERIOD (P)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .line_in        (line_in),
        .rx_en_in       (rx_en_in),
        .code_out       (code_out),
        .x_out          (x_out),
        .y_out          (y_out),
        .color_out      (color_out),
        .sw_out         (sw_out),
        .new_code_out   (new_code_out),
        .busy_out       (busy_out),
        .parity_err_out (parity_err_out),
        .frame_err_out  (frame_err_out)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    // Pulse monitor: counts high cycles of each strobe, sampled mid-cycle.
    always @(negedge clk_in) begin
        if (new_code_out === 1'b1) begin
            new_cnt++;
            last_new_cyc = cyc;
        end
        if (parity_err_out === 1'b1) perr_cnt++;
        if (frame_err_out === 1'b1) ferr_cnt++;
    end

    task automatic tick_n(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic clear_counts();
        new_cnt  = 0;
        perr_cnt = 0;
        ferr_cnt = 0;
    endtask

    task automatic drive_bit(input logic b, input bit glitch);
        if (glitch) begin
            line_in = b;
            tick_n(HALF);
            line_in = ~b;
            tick_n(1);
            line_in = b;
            tick_n(P - HALF - 1);
        end else begin
            line_in = b;
            tick_n(P);
        end
    endtask

    // Full frame; glitch_idx is the frame bit index (0 = start) that gets a 1-cycle mid-bit inversion.
    task automatic send_frame(input logic [25:0] code, input logic par_flip, input logic stop,
                              input int glitch_idx);
        logic [28:0] bits;
        bits = {1'b0, code, (^code) ^ par_flip, stop};
        start_cyc = cyc;
        for (int j = 28; j >= 0; j--) begin
            drive_bit(bits[j], (28 - j) == glitch_idx);
        end
    endtask

    task automatic test_reset();
        rst_in   = 1'b1;
        line_in  = 1'b1;
        rx_en_in = 1'b1;
        tick_n(3);
        n_cmp++;
        if (code_out !== 26'h0) begin
            n_bad++; $display("FAIL reset_code: got %0h expected 0", code_out);
        end
        n_cmp++;
        if ({new_code_out, busy_out, parity_err_out, frame_err_out} !== 4'b0000) begin
            n_bad++; $display("FAIL reset_flags: got %b expected 0000",
                              {new_code_out, busy_out, parity_err_out, frame_err_out});
        end
        n_cmp++;
        if ({x_out, y_out, color_out, sw_out} !== 26'h0) begin
            n_bad++; $display("FAIL reset_fields: got %0h expected 0", {x_out, y_out, color_out, sw_out});
        end
        rst_in = 1'b0;
        tick_n(2);
        n_cmp++;
        if (busy_out !== 1'b0) begin
            n_bad++; $display("FAIL idle_busy: got %b expected 0", busy_out);
        end
    endtask

    task automatic test_nominal();
        clear_counts();
        send_frame(26'h1405A2B, 1'b0, 1'b1, -1);
        tick_n(4);
        n_cmp++;
        if (new_cnt !== 1) begin n_bad++; $display("FAIL nom_new_pulses: got %0d expected 1", new_cnt); end
        n_cmp++;
        if (perr_cnt + ferr_cnt !== 0) begin
            n_bad++; $display("FAIL nom_err_pulses: got %0d expected 0", perr_cnt + ferr_cnt);
        end
        n_cmp++;
        if (code_out !== 26'h1405A2B) begin n_bad++; $display("FAIL nom_code: got %0h expected 1405a2b", code_out); end
        n_cmp++;
        if (x_out !== 10'd320) begin n_bad++; $display("FAIL nom_x: got %0d expected 320", x_out); end
        n_cmp++;
        if (y_out !== 9'd180) begin n_bad++; $display("FAIL nom_y: got %0d expected 180", y_out); end
        n_cmp++;
        if (color_out !== 4'd5) begin n_bad++; $display("FAIL nom_color: got %0d expected 5", color_out); end
        n_cmp++;
        if (sw_out !== 3'd3) begin n_bad++; $display("FAIL nom_sw: got %0d expected 3", sw_out); end
        n_cmp++;
        if (last_new_cyc !== start_cyc + LAT) begin
            n_bad++; $display("FAIL nom_latency: got %0d expected %0d", last_new_cyc, start_cyc + LAT);
        end
        n_cmp++;
        if (busy_out !== 1'b0) begin n_bad++; $display("FAIL nom_busy: got %b expected 0", busy_out); end
    endtask

    // A different payload with bad parity: code_out must keep the previous packet.
    task automatic test_parity();
        clear_counts();
        send_frame(26'h0ABCDEF, 1'b1, 1'b1, -1);
        tick_n(4);
        n_cmp++;
        if (perr_cnt !== 1) begin n_bad++; $display("FAIL par_err_pulses: got %0d expected 1", perr_cnt); end
        n_cmp++;
        if (new_cnt !== 0) begin n_bad++; $display("FAIL par_new_pulses: got %0d expected 0", new_cnt); end
        n_cmp++;
        if (ferr_cnt !== 0) begin n_bad++; $display("FAIL par_ferr_pulses: got %0d expected 0", ferr_cnt); end
        n_cmp++;
        if (code_out !== 26'h1405A2B) begin n_bad++; $display("FAIL par_code_hold: got %0h expected 1405a2b", code_out); end
    endtask

    // Stop low with bad parity too: frame error wins; line then held low before recovering.
    task automatic test_frame_err();
        int low_busy;
        clear_counts();
        send_frame(26'h0123456, 1'b1, 1'b0, -1);
        n_cmp++;
        if (ferr_cnt !== 1) begin n_bad++; $display("FAIL ferr_pulses: got %0d expected 1", ferr_cnt); end
        n_cmp++;
        if (perr_cnt + new_cnt !== 0) begin
            n_bad++; $display("FAIL ferr_other_pulses: got %0d expected 0", perr_cnt + new_cnt);
        end
        low_busy = 0;
        for (int i = 0; i < 50; i++) begin
            tick_n(1);
            if (busy_out !== 1'b1) low_busy++;
        end
        n_cmp++;
        if (low_busy !== 0) begin n_bad++; $display("FAIL ferr_wait_busy: got %0d idle cycles expected 0", low_busy); end
        n_cmp++;
        if (ferr_cnt !== 1) begin n_bad++; $display("FAIL ferr_no_retrigger: got %0d expected 1", ferr_cnt); end
        line_in = 1'b1;
        tick_n(2);
        n_cmp++;
        if (busy_out !== 1'b0) begin n_bad++; $display("FAIL ferr_release_busy: got %b expected 0", busy_out); end
        clear_counts();
        send_frame(26'h155AA55, 1'b0, 1'b1, -1);
        tick_n(4);
        n_cmp++;
        if (new_cnt !== 1) begin n_bad++; $display("FAIL ferr_next_new: got %0d expected 1", new_cnt); end
        n_cmp++;
        if (code_out !== 26'h155AA55) begin n_bad++; $display("FAIL ferr_next_code: got %0h expected 155aa55", code_out); end
    endtask

    task automatic test_glitch();
        clear_counts();
        line_in = 1'b0;
        tick_n(1);
        n_cmp++;
        if (busy_out !== 1'b1) begin n_bad++; $display("FAIL glitch_busy_rise: got %b expected 1", busy_out); end
        line_in = 1'b1;
        tick_n(4);
        n_cmp++;
        if (busy_out !== 1'b0) begin n_bad++; $display("FAIL glitch_busy_drop: got %b expected 0", busy_out); end
        tick_n(P);
        n_cmp++;
        if (new_cnt + perr_cnt + ferr_cnt !== 0) begin
            n_bad++; $display("FAIL glitch_pulses: got %0d expected 0", new_cnt + perr_cnt + ferr_cnt);
        end
    endtask

    task automatic test_reset_abort();
        logic [28:0] bits;
        clear_counts();
        bits = {1'b0, 26'h0F0F0F0, 1'b0, 1'b1};
        for (int j = 28; j >= 18; j--) drive_bit(bits[j], 1'b0);
        rst_in  = 1'b1;
        line_in = bits[17];
        tick_n(2);
        rst_in  = 1'b0;
        line_in = 1'b1;
        tick_n(2 * P);
        n_cmp++;
        if (busy_out !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b expected 0", busy_out); end
        n_cmp++;
        if (code_out !== 26'h0) begin n_bad++; $display("FAIL abort_code_cleared: got %0h expected 0", code_out); end
        n_cmp++;
        if (new_cnt + perr_cnt + ferr_cnt !== 0) begin
            n_bad++; $display("FAIL abort_pulses: got %0d expected 0", new_cnt + perr_cnt + ferr_cnt);
        end
        send_frame(26'h3FFFFFF, 1'b0, 1'b1, -1);
        tick_n(4);
        n_cmp++;
        if (new_cnt !== 1) begin n_bad++; $display("FAIL abort_next_new: got %0d expected 1", new_cnt); end
        n_cmp++;
        if (code_out !== 26'h3FFFFFF) begin n_bad++; $display("FAIL abort_next_code: got %0h expected 3ffffff", code_out); end
    endtask

    task automatic test_enable();
        logic [28:0] bits;
        clear_counts();
        bits = {1'b0, 26'h0000000, 1'b0, 1'b1};
        for (int j = 28; j >= 0; j--) begin
            if (j == 22) rx_en_in = 1'b0;
            drive_bit(bits[j], 1'b0);
        end
        n_cmp++;
        if (busy_out !== 1'b0) begin n_bad++; $display("FAIL en_busy: got %b expected 0", busy_out); end
        rx_en_in = 1'b1;
        tick_n(P);
        n_cmp++;
        if (new_cnt + perr_cnt + ferr_cnt !== 0) begin
            n_bad++; $display("FAIL en_pulses: got %0d expected 0", new_cnt + perr_cnt + ferr_cnt);
        end
        n_cmp++;
        if (code_out !== 26'h3FFFFFF) begin n_bad++; $display("FAIL en_code_hold: got %0h expected 3ffffff", code_out); end
    endtask

    task automatic test_back_to_back();
        int first_new;
        clear_counts();
        send_frame(26'h2000001, 1'b0, 1'b1, -1);
        first_new = new_cnt;
        send_frame(26'h1234567, 1'b0, 1'b1, -1);
        tick_n(4);
        n_cmp++;
        if (first_new !== 1) begin n_bad++; $display("FAIL b2b_first_new: got %0d expected 1", first_new); end
        n_cmp++;
        if (new_cnt !== 2) begin n_bad++; $display("FAIL b2b_new_pulses: got %0d expected 2", new_cnt); end
        n_cmp++;
        if (code_out !== 26'h1234567) begin n_bad++; $display("FAIL b2b_code: got %0h expected 1234567", code_out); end
        n_cmp++;
        if (last_new_cyc !== start_cyc + LAT) begin
            n_bad++; $display("FAIL b2b_latency: got %0d expected %0d", last_new_cyc, start_cyc + LAT);
        end
    endtask

`ifdef DIFF_RX_MAJORITY_EN
    // Single-cycle inversion at the midpoint of data bit 3 (frame bit 4) must be voted out.
    task automatic test_majority();
        clear_counts();
        send_frame(26'h2B5A0C3, 1'b0, 1'b1, 4);
        tick_n(4);
        n_cmp++;
        if (new_cnt !== 1) begin n_bad++; $display("FAIL maj_new_pulses: got %0d expected 1", new_cnt); end
        n_cmp++;
        if (perr_cnt + ferr_cnt !== 0) begin
            n_bad++; $display("FAIL maj_err_pulses: got %0d expected 0", perr_cnt + ferr_cnt);
        end
        n_cmp++;
        if (code_out !== 26'h2B5A0C3) begin n_bad++; $display("FAIL maj_code: got %0h expected 2b5a0c3", code_out); end
        n_cmp++;
        if (last_new_cyc !== start_cyc + LAT) begin
            n_bad++; $display("FAIL maj_latency: got %0d expected %0d", last_new_cyc, start_cyc + LAT);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_nominal();
        test_parity();
        test_frame_err();
        test_glitch();
        test_reset_abort();
        test_enable();
        test_back_to_back();
`ifdef DIFF_RX_MAJORITY_EN
        test_majority();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/diff_rx_frame.md
Name: diff_rx_frame

Overview:
- Dedicated receive-side decoder for the single-wire half-duplex cursor link between boards; the transmit side sends one 26-bit packet per frame.
- Takes the already-synchronized line (output of the existing synchronizer) and frames start/data/parity/stop bits.
- Presents the decoded packet as raw code plus split fields (x, y, color, stroke width), with a one-cycle valid pulse and error flags.
- Sits between the receive synchronizer and the comm_* field registers feeding the frame_buffer's second draw port.

Parameters:
- BIT_PERIOD, 100, clk_in cycles per serial bit; must be ≥ 4.
- CODE_W, 26, payload bits per packet.

Ports:
- clk_in  input  1  system clock (100 MHz buffered).
- rst_in  input  1  synchronous reset, active-high.
- line_in  input  1  synchronized serial line; idles high.
- rx_en_in  input  1  receive enable; low = local side owns the wire (io_sel), so the line is ignored.
- code_out  output  CODE_W  last valid packet, MSB = first data bit.
- x_out  output  10  code_out[25:16].
- y_out  output  9  code_out[15:7].
- color_out  output  4  code_out[6:3].
- sw_out  output  3  code_out[2:0].
- new_code_out  output  1  one-cycle pulse when code_out updates.
- busy_out  output  1  high while in any state except IDLE.
- parity_err_out  output  1  one-cycle pulse on parity mismatch.
- frame_err_out  output  1  one-cycle pulse on stop-bit low.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset:
  - All outputs go to 0.
  - State goes to IDLE; bit counter and cycle counter clear.
  - Reset asserted mid-frame aborts the frame with no pulse.
- Frame format: start (low), CODE_W data bits MSB-first, even-parity bit (XOR of data bits), stop (high). Each bit lasts BIT_PERIOD cycles.
- States:
  - IDLE: wait for line_in == 0 with rx_en_in == 1. Then load the cycle counter and go to START.
  - START: at count BIT_PERIOD/2 (integer division), sample the line.
    - 1 → glitch; return to IDLE, no error.
    - 0 → reset the counter and go to DATA.
  - DATA: sample every BIT_PERIOD cycles from the start-bit midpoint and shift into a CODE_W register. After CODE_W samples, go to PARITY.
  - PARITY: sample one bit; compute the mismatch; go to STOP.
  - STOP: sample one bit.
    - Sample 1 and parity OK → code_out/fields update and new_code_out pulses on the next cycle (latency 1 cycle after the stop-bit sample edge); go to IDLE.
    - Sample 1 and parity bad → parity_err_out pulses, code_out is unchanged; go to IDLE.
    - Sample 0 → frame_err_out pulses (takes priority over parity error); go to WAIT_HIGH.
  - WAIT_HIGH: stay until line_in == 1, then go to IDLE. Prevents a stuck-low line from retriggering.
- Enable: rx_en_in falling mid-frame aborts to IDLE with no pulses. It is sampled every cycle.
- Outputs:
  - Fields are combinational slices of the registered code_out.
  - code_out holds its value between packets.
- Cycle counter: width $clog2(BIT_PERIOD)+1; it wraps to 0 at each sample point.
- Back-to-back frames: a start edge is accepted the first cycle in IDLE after STOP.

Optional Feature:
- Macro: DIFF_RX_MAJORITY_EN.
- Defined: each bit (start, data, parity, stop) is the 2-of-3 majority of samples at mid-1, mid and mid+1. The decision is taken at mid+1, which adds 1 cycle of latency to new_code_out. A single-cycle glitch at mid is rejected.
- Undefined: a single sample at mid.

Decomposition:
- Package diff_link_pkg holds:
  - CODE_W.
  - Field msb/lsb localparams: X_MSB=25, X_LSB=16, Y_MSB=15, Y_LSB=7, COL_MSB=6, COL_LSB=3, SW_MSB=2, SW_LSB=0.
  - Typedef enum rx_state_t {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH}.
  - Typedef struct packed cursor_pkt_t {x, y, color, sw}. The transmitter shares the package.
- Sub-module bit_timer: a counter that emits sample_tick at mid-bit, then every BIT_PERIOD, restartable by a load input.

Test Plan:
- BIT_PERIOD=8; send code 26'h1405A2B (x=320, y=180, color=5, sw=3), parity 0, stop 1 → new_code_out one pulse; x_out=320, y_out=180, color_out=5, sw_out=3; no error pulses.
- Same frame with the parity bit flipped to 1 → parity_err_out one pulse, new_code_out 0, code_out keeps its previous value.
- Stop bit held low, then line low 50 cycles, then high → frame_err_out one pulse, busy_out high until the line returns high, then IDLE; the next valid frame decodes.
- 2-cycle low glitch on an idle line → returns to IDLE after the start sample; no pulses; busy_out low by cycle 5.
- Reset asserted at data bit 10, released, then a full frame of 26'h3FFFFFF (parity 0) → no pulse for the aborted frame; second frame gives code_out=26'h3FFFFFF.
- DIFF_RX_MAJORITY_EN defined: 1-cycle inversion at the midpoint of data bit 3 → decoded correctly; new_code_out arrives 1 cycle later than in the non-macro build.
